// File: rtl/disp_pixel_fifo.sv
// disp_pixel_fifo: single-clock pixel buffer that unpacks IN_W-bit words into
// one RGB888 or RGB565 pixel per request, emitted two cycles later on DSP_DE.
module disp_pixel_fifo #(
   parameter int IN_W       = 64,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  DCLK,
   input  logic                  DRST,
   input  logic                  FIFORST,
   input  logic                  FMT,
   input  logic [IN_W-1:0]       FIFOIN,
   input  logic                  FIFOWR,
   input  logic                  DSP_preDE,
   input  logic [DEPTH_LOG2:0]   WMARK,
   output logic                  BUF_WREADY,
   output logic                  BUF_OVER,
   output logic                  BUF_UNDER,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic [7:0]            DSP_R,
   output logic [7:0]            DSP_G,
   output logic [7:0]            DSP_B,
   output logic                  DSP_DE
);
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int IW    = $clog2(IN_W / 16);
   localparam logic [IW-1:0] LAST16 = IW'(IN_W / 16 - 1);
   localparam logic [IW-1:0] LAST32 = IW'(IN_W / 32 - 1);
   localparam logic [LW-1:0] FULL   = LW'(DEPTH);

   logic [IN_W-1:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wp, r_rp;
   logic [LW-1:0]         r_level;
   logic [IW-1:0]         r_idx;
   logic                  r_fmt, r_over, r_under, r_de1, r_de;
   logic [23:0]           r_pix1, r_pix;

   logic                  w_full, w_empty, w_wr, w_rd, w_last, w_pop;
   logic [IN_W-1:0]       w_head;
   logic [15:0]           w_s16;
   logic [23:0]           w_s24, w_pix;

   assign w_full  = r_level == FULL;
   assign w_empty = r_level == '0;
   assign w_wr    = FIFOWR & ~w_full;
   assign w_rd    = DSP_preDE & ~w_empty;
   assign w_last  = r_idx == (r_fmt ? LAST16 : LAST32);
   assign w_pop   = w_rd & w_last;
   assign w_head  = r_mem[r_rp];

   always_comb begin
      w_s16 = '0;
      w_s24 = '0;
      for (int k = 0; k < IN_W / 16; k++) if (r_idx == IW'(k)) w_s16 = w_head[k*16 +: 16];
      for (int k = 0; k < IN_W / 32; k++) if (r_idx == IW'(k)) w_s24 = w_head[k*32 +: 24];
   end

   // 565 expansion replicates the MSBs so full-scale channels reach 0xFF
   assign w_pix = r_fmt ? {w_s16[15:11], w_s16[15:13], w_s16[10:5], w_s16[10:9],
                           w_s16[4:0], w_s16[4:2]} : w_s24;

   always_ff @(posedge DCLK)
      if (w_wr && !FIFORST) r_mem[r_wp] <= FIFOIN;

   always_ff @(posedge DCLK or posedge DRST)
      if (DRST) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
         r_idx   <= '0;
         r_fmt   <= FMT;
         r_over  <= 1'b0;
         r_under <= 1'b0;
         r_de1   <= 1'b0;
         r_de    <= 1'b0;
         r_pix1  <= '0;
         r_pix   <= '0;
      end else begin
         r_de1  <= DSP_preDE;
         r_pix1 <= (w_rd && !FIFORST) ? w_pix : '0;
         r_de   <= r_de1;
         r_pix  <= r_pix1;
         if (FIFORST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_idx   <= '0;
            r_fmt   <= FMT;
            r_over  <= 1'b0;
            r_under <= 1'b0;
         end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_rd) r_idx <= w_last ? '0 : r_idx + 1'b1;
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
            r_over  <= r_over | (FIFOWR & w_full);
            r_under <= r_under | (DSP_preDE & w_empty);
         end
      end

   assign LEVEL      = r_level;
   assign BUF_WREADY = r_level < WMARK;
   assign BUF_OVER   = r_over;
   assign BUF_UNDER  = r_under;
   assign DSP_DE     = r_de;
   assign {DSP_R, DSP_G, DSP_B} = r_pix;
endmodule

// File: tb/tb_disp_pixel_fifo.sv
// tb_disp_pixel_fifo: directed checks of reset, unpack order, 565 decode,
// overflow/underflow flags and watermark on a 64-bit, 16-deep instance.
module tb_disp_pixel_fifo;
   logic        DCLK = 1'b0, DRST = 1'b1, FIFORST = 1'b0, FMT = 1'b0;
   logic [63:0] FIFOIN = '0;
   logic        FIFOWR = 1'b0, DSP_preDE = 1'b0;
   logic [4:0]  WMARK = 5'd8;
   logic        BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE;
   logic [4:0]  LEVEL;
   logic [7:0]  DSP_R, DSP_G, DSP_B;
   int          n_chk = 0, n_pass = 0;

   disp_pixel_fifo #(.IN_W(64), .DEPTH_LOG2(4)) dut (
      .DCLK(DCLK), .DRST(DRST), .FIFORST(FIFORST), .FMT(FMT), .FIFOIN(FIFOIN),
      .FIFOWR(FIFOWR), .DSP_preDE(DSP_preDE), .WMARK(WMARK), .BUF_WREADY(BUF_WREADY),
      .BUF_OVER(BUF_OVER), .BUF_UNDER(BUF_UNDER), .LEVEL(LEVEL), .DSP_R(DSP_R),
      .DSP_G(DSP_G), .DSP_B(DSP_B), .DSP_DE(DSP_DE)
   );

   always #5 DCLK = ~DCLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic cyc();
      @(posedge DCLK);
      #1;
   endtask

   task automatic chk_pix(input string tag, input logic [23:0] exp);
      chk({tag, ".de"}, 64'(DSP_DE), 64'd1);
      chk({tag, ".rgb"}, 64'({DSP_R, DSP_G, DSP_B}), 64'(exp));
   endtask

   task automatic clr();
      FIFORST = 1'b1;
      cyc();
      FIFORST = 1'b0;
   endtask

   initial begin
      cyc();
      cyc();
      DRST = 1'b0;
      chk("rst.level", 64'(LEVEL), 0);
      chk("rst.de", 64'(DSP_DE), 0);
      chk("rst.rgb", 64'({DSP_R, DSP_G, DSP_B}), 0);
      chk("rst.wready", 64'(BUF_WREADY), 1);
      chk("rst.flags", 64'({BUF_OVER, BUF_UNDER}), 0);

      // async reset mid-stream
      FIFOWR = 1'b1;
      FIFOIN = 64'h00CCBBAA_00332211;
      repeat (3) cyc();
      FIFOWR = 1'b0;
      chk("t1.level3", 64'(LEVEL), 3);
      DSP_preDE = 1'b1;
      cyc();
      cyc();
      chk_pix("t1.pre", 24'h332211);
      DRST = 1'b1;
      #1;
      chk("t1.level0", 64'(LEVEL), 0);
      chk("t1.de0", 64'(DSP_DE), 0);
      chk("t1.rgb0", 64'({DSP_R, DSP_G, DSP_B}), 0);
      chk("t1.wready", 64'(BUF_WREADY), 1);
      DSP_preDE = 1'b0;
      cyc();
      DRST = 1'b0;
      FIFOWR = 1'b1;
      clr();
      FIFOWR = 1'b0;
      chk("t1.fiforst_wr", 64'(LEVEL), 0);

      // RGB888 ordering
      FIFOWR = 1'b1;
      FIFOIN = 64'h00CCBBAA_00332211;
      cyc();
      FIFOWR = 1'b0;
      chk("t2.level1", 64'(LEVEL), 1);
      DSP_preDE = 1'b1;
      cyc();
      chk("t2.level_mid", 64'(LEVEL), 1);
      chk("t2.de_early", 64'(DSP_DE), 0);
      cyc();
      DSP_preDE = 1'b0;
      chk("t2.level_pop", 64'(LEVEL), 0);
      chk_pix("t2.p0", 24'h332211);
      cyc();
      chk_pix("t2.p1", 24'hCCBBAA);
      cyc();
      chk("t2.de_off", 64'(DSP_DE), 0);
      chk("t2.rgb_off", 64'({DSP_R, DSP_G, DSP_B}), 0);

      // RGB565 decode
      FMT = 1'b1;
      clr();
      FIFOWR = 1'b1;
      FIFOIN = 64'h8410_001F_07E0_F800;
      cyc();
      FIFOWR = 1'b0;
      DSP_preDE = 1'b1;
      cyc();
      chk("t3.level_a", 64'(LEVEL), 1);
      cyc();
      chk_pix("t3.p0", 24'hFF0000);
      cyc();
      chk_pix("t3.p1", 24'h00FF00);
      chk("t3.level_b", 64'(LEVEL), 1);
      cyc();
      DSP_preDE = 1'b0;
      chk_pix("t3.p2", 24'h0000FF);
      chk("t3.level_pop", 64'(LEVEL), 0);
      cyc();
      chk_pix("t3.p3", 24'h848284);

      // overflow
      FMT = 1'b0;
      clr();
      FIFOWR = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         FIFOIN = {8'h00, 24'(i + 128), 8'h00, 24'(i)};
         cyc();
         if (i == 16) begin
            chk("t4.level16", 64'(LEVEL), 16);
            chk("t4.over_pre", 64'(BUF_OVER), 0);
            chk("t4.wready_full", 64'(BUF_WREADY), 0);
         end
      end
      FIFOWR = 1'b0;
      chk("t4.level_full", 64'(LEVEL), 16);
      chk("t4.over", 64'(BUF_OVER), 1);
      DSP_preDE = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         if (e == 33) DSP_preDE = 1'b0;
         cyc();
         if (e >= 2 && e <= 33)
            chk_pix($sformatf("t4.rd%0d", e - 2),
                    ((e - 2) % 2) ? 24'((e - 2) / 2 + 129) : 24'((e - 2) / 2 + 1));
      end
      chk("t4.level_empty", 64'(LEVEL), 0);
      chk("t4.over_hold", 64'(BUF_OVER), 1);
      chk("t4.under_none", 64'(BUF_UNDER), 0);
      clr();
      chk("t4.over_clr", 64'(BUF_OVER), 0);

      // underflow
      DSP_preDE = 1'b1;
      cyc();
      DSP_preDE = 1'b0;
      chk("t5.under", 64'(BUF_UNDER), 1);
      chk("t5.level", 64'(LEVEL), 0);
      cyc();
      chk_pix("t5.blank", 24'h000000);
      FIFOWR = 1'b1;
      FIFOIN = 64'h00665544_00030201;
      cyc();
      FIFOWR = 1'b0;
      DSP_preDE = 1'b1;
      cyc();
      cyc();
      DSP_preDE = 1'b0;
      chk_pix("t5.p0", 24'h030201);
      cyc();
      chk_pix("t5.p1", 24'h665544);
      chk("t5.under_hold", 64'(BUF_UNDER), 1);

      // watermark, simultaneous write/pop, FMT without FIFORST
      clr();
      WMARK = 5'd5;
      FIFOWR = 1'b1;
      FIFOIN = 64'h00D0E0F0_00A0B0C0;
      repeat (4) cyc();
      FIFOWR = 1'b0;
      chk("t6.level4", 64'(LEVEL), 4);
      chk("t6.wready4", 64'(BUF_WREADY), 1);
      FIFOWR = 1'b1;
      cyc();
      FIFOWR = 1'b0;
      chk("t6.level5", 64'(LEVEL), 5);
      chk("t6.wready5", 64'(BUF_WREADY), 0);
      DSP_preDE = 1'b1;
      cyc();
      chk("t6.level_idx", 64'(LEVEL), 5);
      FIFOWR = 1'b1;
      cyc();
      FIFOWR = 1'b0;
      FMT = 1'b1;
      chk("t6.level_wrpop", 64'(LEVEL), 5);
      chk_pix("t6.p0", 24'hA0B0C0);
      cyc();
      DSP_preDE = 1'b0;
      chk_pix("t6.p1", 24'hD0E0F0);
      cyc();
      chk_pix("t6.fmt_ignored", 24'hA0B0C0);
      chk("t6.level_end", 64'(LEVEL), 5);
      FMT = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/disp_pixel_fifo.md
Name: disp_pixel_fifo

Overview:
Parametrised single-clock display pixel buffer in the DCLK domain, the successor to the dual-clock 48-in/24-out display FIFO.
- Accepts IN_W-bit words, each packing several pixels, and unpacks one pixel per DSP_preDE cycle.
- Supports RGB888-in-32 and RGB565-in-16 slot formats, with a programmable write-ready watermark and sticky over/underflow flags.
- Emits blanked (zero) RGB aligned to DSP_DE with a fixed 2-cycle latency.
- Sits between the frame-fetch write engine and the video timing/output stage.

Parameters:
IN_W, 64, input word width; multiple of 32, minimum 32.
DEPTH_LOG2, 9, log2 of storage depth in IN_W-bit words (DEPTH = 2^DEPTH_LOG2).

Ports:
DCLK  in  1  pixel clock; all logic is on the rising edge.
DRST  in  1  asynchronous active-high reset.
FIFORST  in  1  synchronous clear of storage, unpacker and flags; also latches FMT.
FMT  in  1  0 = RGB888 (32-bit slots), 1 = RGB565 (16-bit slots); sampled only at DRST and FIFORST.
FIFOIN  in  IN_W  packed pixel word; slot 0 is the least-significant slot.
FIFOWR  in  1  write strobe.
DSP_preDE  in  1  pixel request, 2 cycles ahead of DSP_DE.
WMARK  in  DEPTH_LOG2+1  ready threshold, in words.
BUF_WREADY  out  1  LEVEL < WMARK.
BUF_OVER  out  1  sticky overflow flag.
BUF_UNDER  out  1  sticky underflow flag.
LEVEL  out  DEPTH_LOG2+1  stored word count, range 0..DEPTH.
DSP_R, DSP_G, DSP_B  out  8 each  pixel colour.
DSP_DE  out  1  data enable.

Behaviour:
Reset and clear:
- DRST asynchronously clears pointers, LEVEL, slot index, flags, the DE pipeline and all RGB outputs to 0, and captures FMT.
- BUF_WREADY after reset equals (0 < WMARK).
- FIFORST has the same effect on storage, LEVEL, slot index and flags, and latches FMT.
- FIFORST does not clear the DSP_DE/RGB pipeline.
- FIFORST overrides FIFOWR and DSP_preDE in the same cycle.

Slots per word:
- S = IN_W/32 when latched FMT = 0; S = IN_W/16 when latched FMT = 1.

Write path:
- FIFOWR with LEVEL < DEPTH stores the word.
- FIFOWR with LEVEL = DEPTH drops the word and sets BUF_OVER on the next cycle.
- A pop in the same cycle does not make room: full always blocks the write.

Read path (unpacker):
- Slot index idx runs 0..S-1 on the head word.
- DSP_preDE with LEVEL > 0 consumes slot idx.
  - If idx = S-1, the head word is popped and idx returns to 0; otherwise idx increments.
- DSP_preDE with LEVEL = 0 sets BUF_UNDER on the next cycle.
  - That output pixel is 000000.
  - idx is unchanged.
  - A write arriving in the same cycle is not bypassed to the read.

LEVEL:
- Updates with +1 on a write, -1 on a pop, and no change when both occur in the same cycle.
- BUF_WREADY is derived combinationally from the registered LEVEL.

Output timing:
- Request in cycle t produces DSP_DE = 1 and the pixel in cycle t+2.
- When DSP_DE = 0, RGB is 0.

Colour decode:
- RGB888 slot: B = [7:0], G = [15:8], R = [23:16]; bits [31:24] are ignored.
- RGB565 slot: R5 = [15:11], G6 = [10:5], B5 = [4:0].
  - Expansion: R = {R5, R5[4:2]}, G = {G6, G6[5:4]}, B = {B5, B5[4:2]}.

Flags:
- BUF_OVER and BUF_UNDER stay high until FIFORST or DRST.

Pointers:
- Pointers wrap modulo DEPTH.
- Full and empty are distinguished by LEVEL.

Test Plan:
1. Reset and clear: DRST pulse mid-stream with LEVEL = 3 -> all outputs 0 and LEVEL = 0 immediately; with WMARK = 8, BUF_WREADY = 1. Then FIFORST during an active write -> the write is ignored and LEVEL stays 0.
2. RGB888 ordering (IN_W = 64, FMT = 0): write 0x00CCBBAA_00332211, then preDE at cycles 10 and 11 -> DSP_DE at 12 and 13 with RGB 33/22/11 then CC/BB/AA; LEVEL goes 1 -> 0 after the cycle-11 pop.
3. RGB565 decode (FMT = 1 latched via FIFORST): word 0x8410_001F_07E0_F800 -> pixels FF/00/00, 00/FF/00, 00/00/FF, 84/82/84; a single pop occurs after the 4th request.
4. Overflow (DEPTH_LOG2 = 4): 17 writes with no reads -> LEVEL = 16 and BUF_OVER = 1 one cycle after the 17th write. Reading out returns words 1..16 intact. BUF_OVER holds until FIFORST.
5. Underflow: preDE with the FIFO empty -> DSP_DE = 1 with RGB 000000 two cycles later and BUF_UNDER = 1. A later write plus reads yields correct pixels; BUF_UNDER stays high.
6. Watermark (WMARK = 5): BUF_WREADY = 1 at LEVEL 4 and 0 at LEVEL 5. A simultaneous write and pop at LEVEL 5 keeps LEVEL = 5. FMT toggled without FIFORST -> no decode change.
